// File: rtl/spi_pkg.sv
// Shared widths, defaults and FSM encoding for the SPI slave endpoint.
package spi_pkg;

  localparam int unsigned SPI_WORD_W = 8;
  localparam int unsigned SPI_RX_DEPTH = 4;
  localparam logic [SPI_WORD_W-1:0] SPI_IDLE_WORD = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_fifo.sv
// Synchronous RX FIFO; a push into a full FIFO only succeeds when a pop frees a slot the same cycle.
module spi_slave_rx_fifo #(
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WORD_W-1:0] mem [RX_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(RX_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge mclk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/spi_slave_endpoint.sv
// SPI slave endpoint: LSB-first full-duplex byte link with TX holding register and RX FIFO.
// Define SPI_SLV_LOOPBACK_EN to echo the last received word when no TX word is pending.
module spi_slave_endpoint
  import spi_pkg::*;
#(
  parameter int unsigned       WORD_W    = SPI_WORD_W,
  parameter int unsigned       RX_DEPTH  = SPI_RX_DEPTH,
  parameter logic [WORD_W-1:0] IDLE_WORD = SPI_IDLE_WORD
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              cs,
  input  logic              bit_strobe,
  input  logic              mosi,
  output logic              miso,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              ovr_clr,
  output logic              rx_overrun,
  output logic              frame_abort
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  spi_state_e        state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [WORD_W-1:0] rx_shift, rx_shift_n;
  logic [WORD_W-1:0] tx_shift, tx_shift_n;
  logic [WORD_W-1:0] hold;
  logic              hold_valid;
  logic              take_c;
  logic              tx_load_c;
  logic              abort_n;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] reload_c;

  // tx_ready is the registered "holding register empty" flag
  assign hold_valid = !tx_ready;
  assign miso       = tx_shift[0];
  assign rx_valid   = !fifo_empty;
  assign pop_c      = rx_valid && rx_ready;
  assign drop_c     = push_c && fifo_full && !pop_c;
  assign take_c     = (state == IDLE) && !cs && bit_strobe;
  // a load colliding with the frame-start consume is deferred to a later cycle
  assign tx_load_c  = tx_valid && tx_ready && !take_c;

`ifdef SPI_SLV_LOOPBACK_EN
  logic [WORD_W-1:0] last_rx;

  always_ff @(posedge mclk) begin
    if (!reset)      last_rx <= IDLE_WORD;
    else if (push_c) last_rx <= rx_shift;
  end

  assign reload_c = hold_valid ? hold : last_rx;
`else
  assign reload_c = hold_valid ? hold : IDLE_WORD;
`endif

  // next-state and datapath decode
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    rx_shift_n = rx_shift;
    tx_shift_n = tx_shift;
    abort_n    = 1'b0;
    push_c     = 1'b0;
    case (state)
      IDLE: begin
        tx_shift_n = reload_c;
        if (take_c) begin
          rx_shift_n = {mosi, rx_shift[WORD_W-1:1]};
          tx_shift_n = tx_shift >> 1;
          bit_cnt_n  = CNT_W'(1);
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        if (cs) begin
          abort_n   = 1'b1;
          bit_cnt_n = '0;
          state_n   = IDLE;
        end else if (bit_strobe) begin
          rx_shift_n = {mosi, rx_shift[WORD_W-1:1]};
          tx_shift_n = tx_shift >> 1;
          bit_cnt_n  = bit_cnt + CNT_W'(1);
          if (bit_cnt_n == CNT_W'(WORD_W)) state_n = COMMIT;
        end
      end
      COMMIT: begin
        push_c    = 1'b1;
        bit_cnt_n = '0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold        <= '0;
      tx_ready    <= 1'b1;
      frame_abort <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      rx_shift    <= rx_shift_n;
      tx_shift    <= tx_shift_n;
      frame_abort <= abort_n;
      if (take_c)         tx_ready <= 1'b1;
      else if (tx_load_c) tx_ready <= 1'b0;
      if (tx_load_c) hold <= tx_data;
      // a fresh overrun outranks a simultaneous clear
      if (drop_c)       rx_overrun <= 1'b1;
      else if (ovr_clr) rx_overrun <= 1'b0;
    end
  end

  spi_slave_rx_fifo #(
    .WORD_W   (WORD_W),
    .RX_DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .mclk      (mclk),
    .reset     (reset),
    .push      (push_c),
    .push_data (rx_shift),
    .pop       (pop_c),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_spi_slave_endpoint.sv
// Bench for spi_slave_endpoint: transaction-level model (queue + flags) checked every cycle, plus directed literals.
module tb_spi_slave_endpoint;

  localparam int unsigned W   = 8;
  localparam int          RXD = 4;
`ifdef SPI_SLV_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic         mclk = 1'b0;
  logic         reset = 1'b0;
  logic         cs = 1'b1;
  logic         bit_strobe = 1'b0;
  logic         mosi = 1'b0;
  logic         miso;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic         ovr_clr = 1'b0;
  logic         rx_overrun;
  logic         frame_abort;

  int checks = 0;
  int failures = 0;

  // driver -> model notifications
  bit           start_req = 1'b0;
  bit           push_req = 1'b0;
  bit           abort_req = 1'b0;
  bit           rand_ready = 1'b0;
  int           drv_bit = 0;
  logic [W-1:0] push_word = '0;

  // behavioural model
  logic [W-1:0] mq[$];
  bit           m_ovr, m_hold_v, m_abort, m_pop, m_drop;
  logic [W-1:0] m_hold = '0;
  logic [W-1:0] m_last = 8'hFF;
  logic [W-1:0] cur_tx = '0;

  // observations of the DUT
  logic [W-1:0] cap = '0;
  logic [W-1:0] exp_w;
  logic [W-1:0] popped[$];
  int           abort_seen = 0;
  int           pb, a0, nb;

  spi_slave_endpoint dut (
    .mclk        (mclk),
    .reset       (reset),
    .cs          (cs),
    .bit_strobe  (bit_strobe),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .ovr_clr     (ovr_clr),
    .rx_overrun  (rx_overrun),
    .frame_abort (frame_abort)
  );

  always #5 mclk = ~mclk;

  function automatic logic [W-1:0] dflt();
    return LOOPBACK ? m_last : 8'hFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // nbits<8 raises cs mid-frame; pop_at_commit raises rx_ready for exactly the commit cycle
  task automatic send_frame(input logic [W-1:0] w, input int nbits, input bit pop_at_commit);
    for (int i = 0; i < nbits; i++) begin
      cs         = 1'b0;
      bit_strobe = 1'b1;
      mosi       = w[i];
      drv_bit    = i;
      start_req  = (i == 0);
      step();
    end
    bit_strobe = 1'b0;
    start_req  = 1'b0;
    cs         = 1'b1;
    if (nbits == int'(W)) begin
      push_req  = 1'b1;
      push_word = w;
      if (pop_at_commit) rx_ready = 1'b1;
      step();
      push_req = 1'b0;
      if (pop_at_commit) rx_ready = 1'b0;
    end else begin
      abort_req = 1'b1;
      step();
      abort_req = 1'b0;
    end
  endtask

  task automatic pop_n(input int n);
    rx_ready = 1'b1;
    repeat (n) step();
    rx_ready = 1'b0;
    step();
  endtask

  always @(posedge mclk) begin
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  end

  // model: FIFO as a queue, overrun flag, holding register
  always @(posedge mclk) begin
    if (!reset) begin
      mq.delete();
      m_ovr    = 1'b0;
      m_hold_v = 1'b0;
      m_abort  = 1'b0;
      m_last   = 8'hFF;
    end else begin
      m_pop = (mq.size() != 0) && rx_ready;
      if (m_pop) void'(mq.pop_front());
      m_drop = 1'b0;
      if (push_req) begin
        m_last = push_word;
        if (mq.size() < RXD) mq.push_back(push_word);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
      m_abort = abort_req;
      if (start_req) begin
        cur_tx   = m_hold_v ? m_hold : dflt();
        m_hold_v = 1'b0;
      end else if (tx_valid && !m_hold_v) begin
        m_hold_v = 1'b1;
        m_hold   = tx_data;
      end
    end
  end

  // compare process
  always @(negedge mclk) begin
    if (reset) begin
      chk("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("rx_data", 32'(rx_data), 32'(mq[0]));
      chk("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
      chk("frame_abort", 32'(frame_abort), 32'(m_abort));
      chk("tx_ready", 32'(tx_ready), 32'(!m_hold_v));
      if (!cs && bit_strobe) begin
        exp_w = (drv_bit == 0) ? (m_hold_v ? m_hold : dflt()) : cur_tx;
        chk("miso", 32'(miso), 32'(exp_w[drv_bit]));
        cap = {miso, cap[W-1:1]};
      end
      if (rx_valid && rx_ready) popped.push_back(rx_data);
      if (frame_abort) abort_seen++;
    end
  end

  initial begin
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_tx_ready", 32'(tx_ready), 32'h1);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_overrun", 32'(rx_overrun), 32'h0);
    chk("rst_frame_abort", 32'(frame_abort), 32'h0);
    step();
    reset = 1'b1;
    repeat (3) step();

    // idle word out, A5 in
    send_frame(8'hA5, 8, 1'b0);
    chk("t1_rx_valid", 32'(rx_valid), 32'h1);
    chk("t1_rx_data", 32'(rx_data), 32'hA5);
    chk("t1_miso_word", 32'(cap), 32'hFF);
    pop_n(1);

    // held TX word goes out on the next frame
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (2) step();
    chk("t2_tx_ready_full", 32'(tx_ready), 32'h0);
    send_frame(8'h00, 8, 1'b0);
    chk("t2_miso_word", 32'(cap), 32'h3C);
    chk("t2_tx_ready", 32'(tx_ready), 32'h1);
    pop_n(1);
    repeat (2) step();

    // overrun on the fifth frame
    pb = popped.size();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 8, 1'b0);
      repeat (2) step();
    end
    chk("t3_overrun", 32'(rx_overrun), 32'h1);
    pop_n(4);
    chk("t3_pop_count", 32'(popped.size() - pb), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_pop_data", 32'(popped[pb+i]), 32'(i + 1));
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("t3_ovr_clr", 32'(rx_overrun), 32'h0);
    repeat (2) step();

    // abort after 3 bits, then a clean frame
    a0 = abort_seen;
    send_frame(8'hFF, 3, 1'b0);
    step();
    chk("t4_abort_pulse", 32'(abort_seen - a0), 32'd1);
    chk("t4_fifo_empty", 32'(rx_valid), 32'h0);
    step();
    send_frame(8'h81, 8, 1'b0);
    chk("t4_rx_data", 32'(rx_data), 32'h81);
    pop_n(1);
    repeat (2) step();

    // full FIFO with commit and pop in the same cycle
    pb = popped.size();
    for (int i = 0; i < 4; i++) begin
      send_frame(8'(8'h10 + i), 8, 1'b0);
      repeat (2) step();
    end
    send_frame(8'h14, 8, 1'b1);
    chk("t5_no_overrun", 32'(rx_overrun), 32'h0);
    pop_n(5);
    chk("t5_pop_count", 32'(popped.size() - pb), 32'd5);
    for (int i = 0; i < 5; i++) chk("t5_pop_data", 32'(popped[pb+i]), 32'(8'h10 + i));
    repeat (2) step();

`ifdef SPI_SLV_LOOPBACK_EN
    send_frame(8'h5A, 8, 1'b0);
    pop_n(1);
    repeat (2) step();
    send_frame(8'h00, 8, 1'b0);
    chk("t6_echo_word", 32'(cap), 32'h5A);
    pop_n(1);
    repeat (2) step();
`endif

    // randomized traffic against the model
    rand_ready = 1'b1;
    repeat (80) begin
      if ($urandom_range(0, 1) == 1) begin
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
      end
      ovr_clr = ($urandom_range(0, 7) == 0);
      step();
      ovr_clr = 1'b0;
      step();
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : int'(W);
      send_frame(8'($urandom), nb, 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end
    rand_ready = 1'b0;
    #2;
    rx_ready = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
